// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lcd_pkg                                                |
// | Description : Shared types and constants for the HD44780 4-bit bus  |
// |               decoder (state encoding, command codes, DDRAM layout). |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package lcd_pkg;

  typedef enum logic [1:0] {
    INIT8 = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2,
    CLR   = 2'd3
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_SETADDR_MASK = 8'h80;
  localparam logic [6:0] ROW1_BASE        = 7'h40;
  localparam logic [7:0] CHAR_SPACE       = 8'h20;
  localparam int         ROW_LEN          = 16;

endpackage
`default_nettype wire

// File: rtl/lcd_nibble_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lcd_nibble_decoder_if                                  |
// | Description : HD44780 4-bit write bus (E strobe, RS, RW, D7..D4).    |
// |               master = host driving the LCD, slave = decoder.        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface lcd_nibble_decoder_if;

  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] nibble;

  modport master (output lcd_e, output lcd_rs, output lcd_rw, output nibble);
  modport slave  (input  lcd_e, input  lcd_rs, input  lcd_rw, input  nibble);

endinterface
`default_nettype wire

// File: rtl/lcd_strobe_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lcd_strobe_detect                                      |
// | Description : Optional input synchronizers, E high-time counter and  |
// |               falling-edge / glitch detection. Bus fields are taken  |
// |               from the last sample where E was high.                 |
// |               Macro LCD_NIBBLE_DECODER_SYNC_EN adds 2-flop syncs.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module lcd_strobe_detect #(
  parameter int E_MIN_HIGH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] nibble,
  output logic       strobe,
  output logic       glitch,
  output logic       cap_rs,
  output logic       cap_rw,
  output logic [3:0] cap_nib
);

  // Counter only needs to reach E_MIN_HIGH; it saturates there.
  localparam int             CW        = (E_MIN_HIGH < 1) ? 1 : $clog2(E_MIN_HIGH + 1);
  localparam logic [CW-1:0]  HI_TARGET = CW'(E_MIN_HIGH);

  logic       w_e;
  logic       w_rs;
  logic       w_rw;
  logic [3:0] w_nib;

`ifdef LCD_NIBBLE_DECODER_SYNC_EN
  logic [1:0] r_e_sync;
  logic [1:0] r_rs_sync;
  logic [1:0] r_rw_sync;
  logic [3:0] r_nib_s1;
  logic [3:0] r_nib_s2;

  // Two-flop synchronizers for the asynchronous LCD bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_sync  <= 2'b00;
      r_rs_sync <= 2'b00;
      r_rw_sync <= 2'b00;
      r_nib_s1  <= 4'h0;
      r_nib_s2  <= 4'h0;
    end else begin
      r_e_sync  <= {r_e_sync[0], lcd_e};
      r_rs_sync <= {r_rs_sync[0], lcd_rs};
      r_rw_sync <= {r_rw_sync[0], lcd_rw};
      r_nib_s1  <= nibble;
      r_nib_s2  <= r_nib_s1;
    end
  end

  assign w_e   = r_e_sync[1];
  assign w_rs  = r_rs_sync[1];
  assign w_rw  = r_rw_sync[1];
  assign w_nib = r_nib_s2;
`else
  assign w_e   = lcd_e;
  assign w_rs  = lcd_rs;
  assign w_rw  = lcd_rw;
  assign w_nib = nibble;
`endif

  logic          r_e_prev;
  logic [CW-1:0] r_hi_cnt;
  logic          w_fall;

  // Track E history, count consecutive high samples and latch bus fields while E is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_prev <= 1'b0;
      r_hi_cnt <= '0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_nib  <= 4'h0;
    end else begin
      r_e_prev <= w_e;
      if (w_e) begin
        if (r_hi_cnt != HI_TARGET) begin
          r_hi_cnt <= r_hi_cnt + CW'(1);
        end
        cap_rs  <= w_rs;
        cap_rw  <= w_rw;
        cap_nib <= w_nib;
      end else begin
        r_hi_cnt <= '0;
      end
    end
  end

  assign w_fall = r_e_prev & ~w_e;
  assign strobe = w_fall & (r_hi_cnt == HI_TARGET);
  assign glitch = w_fall & (r_hi_cnt != HI_TARGET);

endmodule
`default_nettype wire

// File: rtl/lcd_nibble_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lcd_nibble_decoder                                     |
// | Description : Passive HD44780 4-bit-mode bus decoder. Reassembles    |
// |               bytes, tracks the cursor and mirrors a 2x16 DDRAM.     |
// |               Macro LCD_NIBBLE_DECODER_SYNC_EN adds input syncs.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module lcd_nibble_decoder
  import lcd_pkg::*;
#(
  parameter int E_MIN_HIGH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  lcd_nibble_decoder_if.slave        bus,
  input  logic [4:0]                 rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       byte_valid,
  output logic [7:0]                 byte_data,
  output logic                       byte_is_data,
  output logic [4:0]                 cursor,
  output logic                       busy,
  output logic [3:0]                 err
);

  localparam logic [1:0] S_INIT8 = INIT8;
  localparam logic [1:0] S_HI    = HI;
  localparam logic [1:0] S_LO    = LO;
  localparam logic [1:0] S_CLR   = CLR;
  localparam logic [4:0] CLR_LAST = 5'(2 * ROW_LEN - 1);

  logic       w_strobe, w_glitch, w_cap_rs, w_cap_rw;
  logic [3:0] w_cap_nib;

  lcd_strobe_detect #(
    .E_MIN_HIGH (E_MIN_HIGH)
  ) u_strobe (
    .clk     (clk),
    .rst     (rst),
    .lcd_e   (bus.lcd_e),
    .lcd_rs  (bus.lcd_rs),
    .lcd_rw  (bus.lcd_rw),
    .nibble  (bus.nibble),
    .strobe  (w_strobe),
    .glitch  (w_glitch),
    .cap_rs  (w_cap_rs),
    .cap_rw  (w_cap_rw),
    .cap_nib (w_cap_nib)
  );

  logic [1:0] r_state;
  logic [3:0] r_hi_nib;
  logic       r_hi_rs;
  logic [4:0] r_clr_idx;
  logic [7:0] r_mem [0:31];

  logic       w_busy, w_accept, w_setaddr, w_addr_ok;
  logic [4:0] w_addr_idx;
  logic [7:0] w_byte;
  logic [3:0] w_err_set;

  // Strobe qualification, command decode and error-flag sources.
  always_comb begin
    w_busy     = (r_state == S_CLR);
    w_accept   = w_strobe & ~w_busy & ~w_cap_rw;
    w_byte     = {r_hi_nib, w_cap_nib};
    w_setaddr  = byte_valid & ~byte_is_data & ((byte_data & CMD_SETADDR_MASK) != 8'h00);
    // Only offsets 0x00-0x0F of either row land inside the 16-wide window.
    w_addr_ok  = ((byte_data[6:0] & 7'h70) == 7'h00) ||
                 ((byte_data[6:0] & 7'h70) == ROW1_BASE);
    w_addr_idx = {byte_data[6], byte_data[3:0]};
    w_err_set  = 4'b0000;
    w_err_set[3] = w_strobe & w_busy;
    w_err_set[2] = w_glitch;
    w_err_set[1] = (w_accept && r_state == S_INIT8 && w_cap_nib != 4'h3 && w_cap_nib != 4'h2) ||
                   (w_accept && r_state == S_LO && w_cap_rs != r_hi_rs) ||
                   (w_setaddr && !w_addr_ok);
    w_err_set[0] = w_strobe & ~w_busy & w_cap_rw;
  end

  assign busy    = w_busy;
  assign rd_data = r_mem[rd_addr];

  // Protocol FSM, byte assembly, cursor tracking and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_INIT8;
      r_hi_nib     <= 4'h0;
      r_hi_rs      <= 1'b0;
      r_clr_idx    <= 5'd0;
      cursor       <= 5'd0;
      byte_valid   <= 1'b0;
      byte_data    <= 8'h00;
      byte_is_data <= 1'b0;
      err          <= 4'b0000;
    end else begin
      byte_valid <= 1'b0;
      err        <= err | w_err_set;

      // Act on the byte published last cycle.
      if (byte_valid && byte_is_data) begin
        cursor <= {cursor[4], cursor[3:0] + 4'd1};
      end else if (w_setaddr) begin
        if (w_addr_ok) begin
          cursor <= w_addr_idx;
        end
      end else if (byte_valid && byte_data == CMD_HOME) begin
        cursor <= 5'd0;
      end

      case (r_state)
        S_INIT8: begin
          if (w_accept && w_cap_nib == 4'h2) begin
            r_state <= S_HI;
          end
        end
        S_HI: begin
          if (w_accept) begin
            r_hi_nib <= w_cap_nib;
            r_hi_rs  <= w_cap_rs;
            r_state  <= S_LO;
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_state <= S_HI;
            if (w_cap_rs == r_hi_rs) begin
              byte_valid   <= 1'b1;
              byte_data    <= w_byte;
              byte_is_data <= w_cap_rs;
              if (!w_cap_rs && w_byte == CMD_CLEAR) begin
                r_state   <= S_CLR;
                r_clr_idx <= 5'd0;
              end
            end
          end
        end
        default: begin
          r_clr_idx <= r_clr_idx + 5'd1;
          if (r_clr_idx == CLR_LAST) begin
            r_state <= S_HI;
            cursor  <= 5'd0;
          end
        end
      endcase
    end
  end

  // DDRAM: filled with spaces on reset or clear, otherwise written by data bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= CHAR_SPACE;
      end
    end else if (r_state == S_CLR) begin
      r_mem[r_clr_idx] <= CHAR_SPACE;
    end else if (byte_valid && byte_is_data) begin
      r_mem[cursor] <= byte_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_nibble_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_lcd_nibble_decoder                                  |
// | Description : Directed self-checking bench for lcd_nibble_decoder.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_lcd_nibble_decoder;

`ifdef LCD_NIBBLE_DECODER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic [4:0] cursor;
  logic       busy;
  logic [3:0] err;

  int total = 0;
  int bad = 0;
  int bv_count = 0;
  int busy_cycles = 0;

  lcd_nibble_decoder_if bus ();

  lcd_nibble_decoder #(.E_MIN_HIGH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .cursor       (cursor),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Count byte_valid pulses and busy cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (byte_valid === 1'b1) bv_count++;
    if (busy === 1'b1) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [3:0] n, input logic rs, input logic rw, input int hi);
    @(posedge clk); #1;
    bus.nibble = n; bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_e = 1'b1;
    repeat (hi) @(posedge clk);
    #1 bus.lcd_e = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs);
    strobe(b[7:4], rs, 1'b0, 8);
    strobe(b[3:0], rs, 1'b0, 8);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a; #1;
    check(tag, rd_data, exp);
  endtask

  task automatic init_seq();
    strobe(4'h3, 1'b0, 1'b0, 8);
    strobe(4'h3, 1'b0, 1'b0, 8);
    strobe(4'h3, 1'b0, 1'b0, 8);
    strobe(4'h2, 1'b0, 1'b0, 8);
  endtask

  initial begin
    int bv_before;
    int spaces;
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.nibble = 4'h0;
    rd_addr = 5'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cursor", cursor, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_bv", byte_valid, 1'b0);
    check("rst_bdata", byte_data, 8'h00);
    check("rst_isdata", byte_is_data, 1'b0);
    check("rst_err", err, 4'h0);
    rd_check("rst_mem0", 5'd0, 8'h20);
    rd_check("rst_mem31", 5'd31, 8'h20);

    // Init 3,3,3,2
    init_seq();
    @(negedge clk);
    check("init_bv", bv_count, 0);
    check("init_err", err, 4'h0);

    // Data 0x54 with exact latency: pulse one cycle after detection, write visible after
    strobe(4'h5, 1'b1, 1'b0, 8);
    @(posedge clk); #1;
    bus.nibble = 4'h4; bus.lcd_rs = 1'b1; bus.lcd_e = 1'b1;
    repeat (8) @(posedge clk);
    #1 bus.lcd_e = 1'b0; rd_addr = 5'd0;
    repeat (1 + LAT) @(posedge clk);
    @(negedge clk);
    check("d54_bv_pulse", byte_valid, 1'b1);
    check("d54_same_cycle_old", rd_data, 8'h20);
    @(negedge clk);
    check("d54_bv_once", byte_valid, 1'b0);
    check("d54_rd_new", rd_data, 8'h54);
    check("d54_bdata", byte_data, 8'h54);
    check("d54_isdata", byte_is_data, 1'b1);
    check("d54_cursor", cursor, 5'd1);
    check("d54_bvcount", bv_count, 1);
    repeat (4) @(posedge clk);

    // Row 1 addressing: 0xC0 then 0x41
    send_byte(8'hC0, 1'b0);
    @(negedge clk);
    check("c0_isdata", byte_is_data, 1'b0);
    check("c0_cursor", cursor, 5'd16);
    send_byte(8'h41, 1'b1);
    @(negedge clk);
    rd_check("row1_rd16", 5'd16, 8'h41);
    check("row1_cursor", cursor, 5'd17);

    // Row 0 end wrap: 0x8F then 0x31
    send_byte(8'h8F, 1'b0);
    send_byte(8'h31, 1'b1);
    @(negedge clk);
    rd_check("wrap_rd15", 5'd15, 8'h31);
    check("wrap_cursor", cursor, 5'd0);
    check("pre_clr_err", err, 4'h0);

    // Clear with an overlapping strobe during busy
    busy_cycles = 0;
    send_byte(8'h01, 1'b0);
    strobe(4'h4, 1'b1, 1'b0, 5);
    for (int k = 0; k < 64 && busy === 1'b1; k++) @(negedge clk);
    check("clr_done_in_time", busy, 1'b0);
    check("clr_busy_cycles", busy_cycles, 32);
    check("clr_err_overrun", err, 4'b1000);
    check("clr_cursor", cursor, 5'd0);
    spaces = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      if (rd_data === 8'h20) spaces++;
    end
    check("clr_all_space", spaces, 32);
    send_byte(8'h41, 1'b1);
    @(negedge clk);
    rd_check("post_clr_rd0", 5'd0, 8'h41);

    // Glitch: 2-cycle E pulse ignored
    strobe(4'h7, 1'b1, 1'b0, 2);
    @(negedge clk);
    check("glitch_err", err, 4'b1100);
    send_byte(8'h42, 1'b1);
    @(negedge clk);
    rd_check("glitch_align_rd1", 5'd1, 8'h42);
    check("glitch_cursor", cursor, 5'd2);

    // rw=1 strobe ignored, state unchanged
    strobe(4'h5, 1'b0, 1'b1, 8);
    @(negedge clk);
    check("rw_err", err, 4'b1101);
    send_byte(8'h43, 1'b1);
    @(negedge clk);
    rd_check("rw_align_rd2", 5'd2, 8'h43);

    // rs mismatch between nibbles
    bv_before = bv_count;
    strobe(4'h4, 1'b1, 1'b0, 8);
    strobe(4'h4, 1'b0, 1'b0, 8);
    @(negedge clk);
    check("proto_no_bv", bv_count, bv_before);
    check("proto_err", err, 4'b1111);
    send_byte(8'h44, 1'b1);
    @(negedge clk);
    rd_check("proto_back_hi_rd3", 5'd3, 8'h44);
    check("proto_cursor", cursor, 5'd4);

    // No-op command still pulses, invalid address ignored, home resets cursor
    bv_before = bv_count;
    send_byte(8'h0C, 1'b0);
    @(negedge clk);
    check("noop_bv", bv_count, bv_before + 1);
    check("noop_cursor", cursor, 5'd4);
    send_byte(8'h90, 1'b0);
    @(negedge clk);
    check("badaddr_cursor", cursor, 5'd4);
    send_byte(8'h02, 1'b0);
    @(negedge clk);
    check("home_cursor", cursor, 5'd0);

    // Reset between HI and LO nibbles
    strobe(4'h4, 1'b1, 1'b0, 8);
    @(posedge clk); #1 rst = 1'b1;
    #2;
    check("midrst_err_async", err, 4'h0);
    rd_check("midrst_mem3", 5'd3, 8'h20);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    init_seq();
    send_byte(8'h54, 1'b1);
    @(negedge clk);
    rd_check("replay_rd0", 5'd0, 8'h54);
    check("replay_err", err, 4'h0);
    check("replay_cursor", cursor, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
